// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - command, result and downstream ALU bus of the ALU sequencer
interface alu_seq_if;
   // command channel
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [2:0] in_op;
   logic       in_wide;
   // result channel
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_err;
   logic [7:0] out_count;
   // downstream registered ALU
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [4:0] alu_f;
   logic       alu_v;
   logic       alu_clr_n;
   logic [3:0] alu_y;

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_wide, out_ready, alu_y,
      output in_ready, out_valid, out_data, out_err, out_count,
      output alu_a, alu_b, alu_f, alu_v, alu_clr_n
   );

   modport master (
      output in_valid, in_a, in_b, in_op, in_wide, out_ready, alu_y,
      input  in_ready, out_valid, out_data, out_err, out_count,
      input  alu_a, alu_b, alu_f, alu_v, alu_clr_n
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer issuing one or two nibble operations to an external registered ALU
module alu_seq (
   input  logic     CLK,
   input  logic     CLR,
   alu_seq_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ISS0, CAP0, ISS1, CAP1, OUT} state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_SHL = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_DIV = 3'd7;

   localparam logic [4:0] F_IDLE = 5'b11111;

   state_t     state, state_n;
   logic [3:0] a_q, b_q;
   logic [2:0] op_q;
   logic       wide_q;
   logic [7:0] data_q;
   logic       err_q;
   logic [7:0] count_q;

   logic       div_zero_in;
   logic       two_issue;
   logic [4:0] func;
   logic       ready_c;
   logic [3:0] alu_a_c, alu_b_c;
   logic [4:0] alu_f_c;
   logic       alu_v_c;

   // Division by zero is decided on the incoming command so it can bypass the ALU entirely.
   assign div_zero_in = (bus.in_op == OP_DIV) && (bus.in_b == 4'd0);

   // Only arithmetic ops have a meaningful high nibble; logic and shifts stay single issue.
   assign two_issue = wide_q && ((op_q == OP_ADD) || (op_q == OP_SUB) ||
                                 (op_q == OP_MUL) || (op_q == OP_DIV));

   // Translate the latched opcode into the ALU function code.
   always_comb begin
      func = F_IDLE;
      case (op_q)
         OP_ADD:  func = 5'b00010;
         OP_SUB:  func = 5'b00011;
         OP_AND:  func = 5'b01000;
         OP_OR:   func = 5'b01100;
         OP_SHL:  func = 5'b00000;
         OP_SHR:  func = 5'b10000;
         OP_MUL:  func = 5'b00100;
         OP_DIV:  func = 5'b00110;
         default: func = F_IDLE;
      endcase
   end

   // State register, operand latch, result capture and completion counter.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= IDLE;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         op_q    <= 3'd0;
         wide_q  <= 1'b0;
         data_q  <= 8'd0;
         err_q   <= 1'b0;
         count_q <= 8'd0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q    <= bus.in_a;
                  b_q    <= bus.in_b;
                  op_q   <= bus.in_op;
                  wide_q <= bus.in_wide;
                  data_q <= 8'd0;
                  err_q  <= div_zero_in;
               end
            end
            CAP0: data_q[3:0] <= bus.alu_y;
            CAP1: data_q[7:4] <= bus.alu_y;
            OUT: begin
               if (bus.out_ready) begin
                  count_q <= count_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and ALU drive; the ALU sees the idle code with zero operands outside issue/capture.
   always_comb begin
      state_n = state;
      ready_c = 1'b0;
      alu_a_c = 4'd0;
      alu_b_c = 4'd0;
      alu_f_c = F_IDLE;
      alu_v_c = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               state_n = div_zero_in ? OUT : ISS0;
            end
         end
         ISS0, CAP0: begin
            alu_a_c = a_q;
            alu_b_c = b_q;
            alu_f_c = func;
            if (state == ISS0) begin
               state_n = CAP0;
            end else begin
               state_n = two_issue ? ISS1 : OUT;
            end
         end
         ISS1, CAP1: begin
            alu_a_c = a_q;
            alu_b_c = b_q;
            alu_f_c = func;
            alu_v_c = 1'b1;
            state_n = (state == ISS1) ? CAP1 : OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = data_q;
   assign bus.out_err   = err_q;
   assign bus.out_count = count_q;
   assign bus.alu_a     = alu_a_c;
   assign bus.alu_b     = alu_b_c;
   assign bus.alu_f     = alu_f_c;
   assign bus.alu_v     = alu_v_c;
   assign bus.alu_clr_n = ~CLR;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq with a registered ALU model
module tb_alu_seq;

   logic CLK = 1'b0;
   logic CLR = 1'b1;

   alu_seq_if bus ();

   alu_seq dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_count = 8'd0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic       wide;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   // Downstream ALU: registered, cleared by alu_clr_n, result half chosen by alu_v.
   function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [4:0] f, input logic v);
      logic [7:0] r;
      r = 8'd0;
      case (f)
         5'b00010: r = {4'd0, a} + {4'd0, b};
         5'b00011: r = {4'd0, a} - {4'd0, b};
         5'b01000: r = {4'd0, a & b};
         5'b01100: r = {4'd0, a | b};
         5'b00000: r = {4'd0, a} << 1;
         5'b10000: r = {4'd0, a} >> 1;
         5'b00100: r = {4'd0, a} * {4'd0, b};
         5'b00110: r = (b == 4'd0) ? 8'd0 : {a % b, a / b};
         default:  r = 8'd0;
      endcase
      return v ? r[7:4] : r[3:0];
   endfunction

   always @(posedge CLK) begin
      if (!bus.alu_clr_n) bus.alu_y <= 4'd0;
      else                bus.alu_y <= alu_model(bus.alu_a, bus.alu_b, bus.alu_f, bus.alu_v);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      bit f_busy;
      @(negedge CLK);
      check($sformatf("vec%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      bus.in_op    = v.op;
      bus.in_wide  = v.wide;
      bus.in_valid = 1'b1;
      f_busy = (bus.alu_f != 5'b11111);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.in_a     = ~v.a;
      bus.in_b     = v.b ^ 4'h5;
      bus.in_op    = v.op + 3'd3;
      bus.in_wide  = ~v.wide;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         if (bus.alu_f != 5'b11111) f_busy = 1'b1;
         @(negedge CLK);
         lat++;
      end
      if (bus.alu_f != 5'b11111) f_busy = 1'b1;
      check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      check($sformatf("vec%0d_data", idx), 32'(bus.out_data), 32'(v.exp_data));
      check($sformatf("vec%0d_err", idx), 32'(bus.out_err), 32'(v.exp_err));
      if (v.exp_err) check($sformatf("vec%0d_alu_idle", idx), 32'(f_busy), 32'd0);
      bus.out_ready = 1'b1;
      @(negedge CLK);
      bus.out_ready = 1'b0;
      exp_count = exp_count + 8'd1;
      check($sformatf("vec%0d_count", idx), 32'(bus.out_count), 32'(exp_count));
   endtask

   vec_t vecs[16];

   initial begin
      int  cyc;
      int  hs;
      bit  seen;

      vecs[0]  = '{4'd14, 4'd6,  3'd0, 1'b1, 8'h14, 1'b0, 5};
      vecs[1]  = '{4'd14, 4'd6,  3'd1, 1'b0, 8'h08, 1'b0, 3};
      vecs[2]  = '{4'd14, 4'd6,  3'd6, 1'b1, 8'h54, 1'b0, 5};
      vecs[3]  = '{4'd14, 4'd6,  3'd7, 1'b1, 8'h22, 1'b0, 5};
      vecs[4]  = '{4'd14, 4'd6,  3'd2, 1'b0, 8'h06, 1'b0, 3};
      vecs[5]  = '{4'd14, 4'd6,  3'd5, 1'b0, 8'h07, 1'b0, 3};
      vecs[6]  = '{4'd9,  4'd0,  3'd7, 1'b1, 8'h00, 1'b1, 1};
      vecs[7]  = '{4'd14, 4'd6,  3'd2, 1'b1, 8'h06, 1'b0, 3};
      vecs[8]  = '{4'd14, 4'd6,  3'd3, 1'b0, 8'h0E, 1'b0, 3};
      vecs[9]  = '{4'd5,  4'd7,  3'd4, 1'b1, 8'h0A, 1'b0, 3};
      vecs[10] = '{4'd3,  4'd5,  3'd1, 1'b1, 8'hFE, 1'b0, 5};
      vecs[11] = '{4'd14, 4'd6,  3'd0, 1'b0, 8'h04, 1'b0, 3};
      vecs[12] = '{4'd15, 4'd15, 3'd6, 1'b1, 8'hE1, 1'b0, 5};
      vecs[13] = '{4'd7,  4'd2,  3'd7, 1'b0, 8'h03, 1'b0, 3};
      vecs[14] = '{4'd9,  4'd0,  3'd7, 1'b0, 8'h00, 1'b1, 1};
      vecs[15] = '{4'd14, 4'd6,  3'd6, 1'b0, 8'h04, 1'b0, 3};

      bus.in_valid  = 1'b0;
      bus.in_a      = 4'd0;
      bus.in_b      = 4'd0;
      bus.in_op     = 3'd0;
      bus.in_wide   = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_err",   32'(bus.out_err),   32'd0);
      check("rst_out_count", 32'(bus.out_count), 32'd0);
      check("rst_alu_f",     32'(bus.alu_f),     32'h1F);
      check("rst_alu_a",     32'(bus.alu_a),     32'd0);
      check("rst_alu_clr_n", 32'(bus.alu_clr_n), 32'd0);
      CLR = 1'b0;

      // CLR pulse during CAP0 of a wide MUL aborts it
      @(negedge CLK);
      check("run_alu_clr_n", 32'(bus.alu_clr_n), 32'd1);
      bus.in_a = 4'd14; bus.in_b = 4'd6; bus.in_op = 3'd6; bus.in_wide = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge CLK);
      bus.in_valid = 1'b0;
      check("iss0_alu_f", 32'(bus.alu_f), 32'h04);
      check("iss0_alu_v", 32'(bus.alu_v), 32'd0);
      check("iss0_alu_a", 32'(bus.alu_a), 32'd14);
      check("iss0_alu_b", 32'(bus.alu_b), 32'd6);
      @(negedge CLK);
      check("cap0_alu_y", 32'(bus.alu_y), 32'd4);
      check("cap0_alu_f", 32'(bus.alu_f), 32'h04);
      CLR = 1'b1;
      #1;
      check("abort_alu_clr_n", 32'(bus.alu_clr_n), 32'd0);
      @(negedge CLK);
      CLR = 1'b0;
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      seen = 1'b0;
      repeat (8) begin
         if (bus.out_valid) seen = 1'b1;
         @(negedge CLK);
      end
      check("abort_no_valid", 32'(seen), 32'd0);
      check("abort_count", 32'(bus.out_count), 32'd0);
      exp_count = 8'd0;

      // directed vectors
      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // output stall, then no acceptance during the handshake cycle
      @(negedge CLK);
      bus.in_a = 4'd14; bus.in_b = 4'd6; bus.in_op = 3'd0; bus.in_wide = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge CLK);
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(negedge CLK);
         cyc++;
      end
      for (int k = 0; k < 4; k++) begin
         check($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
         check($sformatf("stall%0d_data", k),  32'(bus.out_data),  32'h14);
         check($sformatf("stall%0d_ready", k), 32'(bus.in_ready),  32'd0);
         check($sformatf("stall%0d_count", k), 32'(bus.out_count), 32'(exp_count));
         @(negedge CLK);
      end
      bus.out_ready = 1'b1;
      bus.in_op = 3'd2; bus.in_wide = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge CLK);
      bus.out_ready = 1'b0;
      exp_count = exp_count + 8'd1;
      check("post_hs_in_ready",  32'(bus.in_ready),  32'd1);
      check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_hs_count",     32'(bus.out_count), 32'(exp_count));
      bus.in_valid = 1'b0;

      // 256 back-to-back AND commands wrap the counter
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      check("wrap_start_count", 32'(bus.out_count), 32'd0);
      bus.in_a = 4'd14; bus.in_b = 4'd6; bus.in_op = 3'd2; bus.in_wide = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      hs  = 0;
      cyc = 0;
      while (hs < 256 && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
         if (bus.out_valid) begin
            hs++;
            if (hs == 1)   check("wrap_first_data", 32'(bus.out_data), 32'h06);
            if (hs == 256) begin
               check("wrap_pre_count", 32'(bus.out_count), 32'd255);
               bus.in_valid = 1'b0;
            end
         end
      end
      check("wrap_handshakes", 32'(hs), 32'd256);
      @(negedge CLK);
      bus.out_ready = 1'b0;
      check("wrap_count", 32'(bus.out_count), 32'd0);
      check("wrap_idle",  32'(bus.in_ready),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
